// File: rtl/tc_pad_input_filter.sv
// Pad input conditioning: synchronizes a raw IO-cell level into clk_i and
// debounces it with a programmable stability window, producing a clean level
// plus one-cycle rise/fall pulses.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_STABLE   | synchronized input matches data_o (or filter disabled), cnt = 0
// ST_SETTLING | synchronized input differs from data_o, counting samples
//
module tc_pad_input_filter #(
  parameter int SyncStages = 2,
  parameter int CntWidth   = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                pad_i,
  input  logic                en_i,
  input  logic [CntWidth-1:0] debounce_cycles_i,
  output logic                data_o,
  output logic                rise_o,
  output logic                fall_o,
  output logic                settling_o
);

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_SETTLING = 1'b1
  } state_e;

  logic [SyncStages-1:0] sync_q, sync_d;
  logic                  sync;

  state_e                state_q, state_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic                  data_q, data_d;
  logic                  rise_q, rise_d;
  logic                  fall_q, fall_d;

  // Shift the raw pad level through the synchronizer; runs regardless of en_i.
  always_comb begin
    sync_d = {sync_q[SyncStages-2:0], pad_i};
  end

  assign sync = sync_q[SyncStages-1];

  // Debounce decision: a difference must persist N+1 samples to be accepted.
  // The >= compare means lowering the threshold below the running count
  // accepts on the next cycle, and the counter can never wrap.
  always_comb begin
    state_d = ST_STABLE;
    cnt_d   = '0;
    data_d  = data_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (en_i && (sync != data_q)) begin
      if (cnt_q >= debounce_cycles_i) begin
        data_d = sync;
        rise_d = sync;
        fall_d = ~sync;
      end else begin
        cnt_d   = cnt_q + 1'b1;
        state_d = ST_SETTLING;
      end
    end
  end

  // All state and outputs are registered; reset clears everything at once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= '0;
      state_q <= ST_STABLE;
      cnt_q   <= '0;
      data_q  <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign data_o     = data_q;
  assign rise_o     = rise_q;
  assign fall_o     = fall_q;
  assign settling_o = (state_q == ST_SETTLING);

endmodule

// File: tb/tb_tc_pad_input_filter.sv
// Directed bench for tc_pad_input_filter (SyncStages = 2, CntWidth = 8).
// Inputs change on the falling edge; outputs are sampled 1 time unit after
// the rising edge. Expected values are packed as {data, rise, fall, settling}.
module tb_tc_pad_input_filter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pad = 1'b0;
  logic       en = 1'b0;
  logic [7:0] n_cyc = 8'd0;
  logic       data, rise, fall, settling;

  int errs = 0;
  int checks = 0;

  typedef struct {
    logic       pad;
    logic [7:0] n;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs[$];

  tc_pad_input_filter #(.SyncStages(2), .CntWidth(8)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .pad_i            (pad),
    .en_i             (en),
    .debounce_cycles_i(n_cyc),
    .data_o           (data),
    .rise_o           (rise),
    .fall_o           (fall),
    .settling_o       (settling)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running want finished");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got {d,r,f,s}=%b want %b", name, act, exp);
    end
  endtask

  function automatic logic [3:0] outs();
    return {data, rise, fall, settling};
  endfunction

  task automatic step(input logic r, input logic p, input logic e, input logic [7:0] n);
    @(negedge clk);
    rst_n = r;
    pad   = p;
    en    = e;
    n_cyc = n;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic p, input logic [7:0] n,
                     input logic d, input logic r, input logic f, input logic s);
    vec_t v;
    v.pad = p;
    v.n   = n;
    v.exp = {d, r, f, s};
    vecs.push_back(v);
  endtask

  initial begin
    // clean rise, N = 3
    add(1,3, 0,0,0,0); add(1,3, 0,0,0,0); add(1,3, 0,0,0,1); add(1,3, 0,0,0,1);
    add(1,3, 0,0,0,1); add(1,3, 1,1,0,0); add(1,3, 1,0,0,0);
    // clean fall, N = 3
    add(0,3, 1,0,0,0); add(0,3, 1,0,0,0); add(0,3, 1,0,0,1); add(0,3, 1,0,0,1);
    add(0,3, 1,0,0,1); add(0,3, 0,0,1,0); add(0,3, 0,0,0,0);
    // 3-cycle glitch is discarded
    add(1,3, 0,0,0,0); add(1,3, 0,0,0,0); add(1,3, 0,0,0,1); add(0,3, 0,0,0,1);
    add(0,3, 0,0,0,1); add(0,3, 0,0,0,0); add(0,3, 0,0,0,0);
    // 4-cycle high is accepted
    add(1,3, 0,0,0,0); add(1,3, 0,0,0,0); add(1,3, 0,0,0,1); add(1,3, 0,0,0,1);
    add(1,3, 0,0,0,1); add(1,3, 1,1,0,0);
    add(0,3, 1,0,0,0); add(0,3, 1,0,0,0); add(0,3, 1,0,0,1); add(0,3, 1,0,0,1);
    add(0,3, 1,0,0,1); add(0,3, 0,0,1,0); add(0,3, 0,0,0,0);
    // N = 0 pass-through, toggle every 4 cycles, 3-cycle latency
    add(1,0, 0,0,0,0); add(1,0, 0,0,0,0); add(1,0, 1,1,0,0); add(1,0, 1,0,0,0);
    add(0,0, 1,0,0,0); add(0,0, 1,0,0,0); add(0,0, 0,0,1,0); add(0,0, 0,0,0,0);
    add(1,0, 0,0,0,0); add(1,0, 0,0,0,0); add(1,0, 1,1,0,0); add(1,0, 1,0,0,0);
    add(1,0, 1,0,0,0); add(1,0, 1,0,0,0);

    // Reset held with pad high: everything stays 0
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 8'd3);
    chk("reset_hold", outs(), 4'b0000);
    // Release, N = 3: rise at edge 6
    for (int i = 1; i <= 7; i++) begin
      step(1'b1, 1'b1, 1'b1, 8'd3);
      if (i == 5) chk("reset_rel_e5", outs(), 4'b0001);
      if (i == 6) chk("reset_rel_e6", outs(), 4'b1100);
      if (i == 7) chk("reset_rel_e7", outs(), 4'b1000);
    end

    // Lowering threshold below running count accepts on the next cycle
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b1, 8'd10);
    chk("lower_n_counting", outs(), 4'b1001);
    step(1'b1, 1'b0, 1'b1, 8'd2);
    chk("lower_n_accept", outs(), 4'b0010);
    step(1'b1, 1'b0, 1'b1, 8'd2);
    chk("lower_n_after", outs(), 4'b0000);

    // Table-driven vectors
    foreach (vecs[i]) begin
      step(1'b1, vecs[i].pad, 1'b1, vecs[i].n);
      chk($sformatf("vec%0d", i), outs(), vecs[i].exp);
    end

    // Enable gating, N = 2: first settle data low
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 8'd0);
    chk("gate_pre", outs(), 4'b0000);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, i[0], 1'b0, 8'd2);
      chk($sformatf("gate_off%0d", i), outs(), 4'b0000);
    end
    step(1'b1, 1'b1, 1'b0, 8'd2);
    step(1'b1, 1'b1, 1'b0, 8'd2);
    chk("gate_off_sync1", outs(), 4'b0000);
    step(1'b1, 1'b1, 1'b1, 8'd2);
    chk("reen_e1", outs(), 4'b0001);
    step(1'b1, 1'b1, 1'b1, 8'd2);
    chk("reen_e2", outs(), 4'b0001);
    step(1'b1, 1'b1, 1'b1, 8'd2);
    chk("reen_e3", outs(), 4'b1100);

    // Reset mid-count, N = 10
    step(1'b0, 1'b0, 1'b1, 8'd10);
    chk("midrst_pre", outs(), 4'b0000);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b1, 8'd10);
    chk("midrst_cnt5", outs(), 4'b0001);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_async", outs(), 4'b0000);
    for (int i = 1; i <= 13; i++) begin
      step(1'b1, 1'b1, 1'b1, 8'd10);
      if (i == 12) chk("midrst_e12", outs(), 4'b0001);
      if (i == 13) chk("midrst_e13", outs(), 4'b1100);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
